// File: rtl/bcd_stopwatch_datapath_pkg.sv
// Shared constants and helpers for the BCD stopwatch datapath.
package bcd_stopwatch_datapath_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Terminal prescaler value; the caller narrows it to its counter width.
  function automatic int unsigned tick_last(input int unsigned tick_count);
    return tick_count - 32'd1;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_datapath_digit_cell.sv
// One decade of the stopwatch: a 4-bit BCD digit with clear, increment and saturate hold.
module bcd_digit_cell
  import bcd_stopwatch_datapath_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc_en,
  input  logic             hold_max,
  output logic [BCD_W-1:0] digit,
  output logic             is_nine
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc_en && !hold_max) begin
      // Anything at or above nine rolls to zero, so the digit can never leave 0..9.
      if (digit_q >= BCD_MAX) begin
        digit_d = '0;
      end else begin
        digit_d = digit_q + 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_nine = (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_datapath.sv
// Stopwatch datapath: prescaler-driven BCD counter chain with pause, clear, lap freeze
// and wrap/saturate overflow handling.
module bcd_stopwatch_datapath
  import bcd_stopwatch_datapath_pkg::*;
#(
  parameter int DIV_WIDTH  = 24,
  parameter int TICK_COUNT = 5000000,
  parameter int NUM_DIGITS = 3,
  parameter int SAT        = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        clear,
  input  logic                        lap,
  output logic                        tick,
  output logic [BCD_W*NUM_DIGITS-1:0] digits,
  output logic                        lap_active,
  output logic                        overflow
);

  localparam logic [DIV_WIDTH-1:0] TICK_LAST = DIV_WIDTH'(tick_last(TICK_COUNT));

  logic [DIV_WIDTH-1:0]          div_q,        div_d;
  logic                          tick_q,       tick_d;
  logic                          ovf_q,        ovf_d;
  logic                          lap_active_q, lap_active_d;
  logic                          lap_prev_q,   lap_prev_d;
  logic [BCD_W*NUM_DIGITS-1:0]   lap_val_q,    lap_val_d;

  logic                          tick_edge_s;
  logic                          lap_rise_s;
  logic                          all_nines_s;
  logic                          hold_max_s;
  logic [NUM_DIGITS-1:0]         nine_s;
  logic [NUM_DIGITS-1:0]         inc_en_s;
  logic [BCD_W*NUM_DIGITS-1:0]   live_s;

  assign tick_edge_s = run && !clear && (div_q == TICK_LAST);
  assign lap_rise_s  = lap && !lap_prev_q;
  assign all_nines_s = &nine_s;
  assign hold_max_s  = (SAT != 0) && all_nines_s;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      // Digits below this one must all read nine for the carry to reach it.
      localparam logic [NUM_DIGITS-1:0] LOWER_MASK =
        (NUM_DIGITS'(1) << gi) - NUM_DIGITS'(1);

      assign inc_en_s[gi] = tick_edge_s && ((nine_s & LOWER_MASK) == LOWER_MASK);

      bcd_digit_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .clr      (clear),
        .inc_en   (inc_en_s[gi]),
        .hold_max (hold_max_s),
        .digit    (live_s[BCD_W*gi +: BCD_W]),
        .is_nine  (nine_s[gi])
      );
    end
  endgenerate

  always_comb begin
    div_d        = div_q;
    tick_d       = 1'b0;
    ovf_d        = ovf_q;
    lap_active_d = lap_active_q;
    lap_val_d    = lap_val_q;
    lap_prev_d   = lap;

    if (clear) begin
      div_d        = '0;
      ovf_d        = 1'b0;
      lap_active_d = 1'b0;
    end else begin
      if (run) begin
        if (div_q == TICK_LAST) begin
          div_d = '0;
        end else begin
          div_d = div_q + DIV_WIDTH'(1);
        end
      end else begin
        div_d = div_q;
      end

      tick_d = tick_edge_s;

      if (tick_edge_s && all_nines_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end

      // Capture uses the pre-edge live value, even when a tick lands on the same edge.
      if (lap_rise_s) begin
        if (!lap_active_q) begin
          lap_val_d    = live_s;
          lap_active_d = 1'b1;
        end else begin
          lap_active_d = 1'b0;
        end
      end else begin
        lap_active_d = lap_active_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q        <= '0;
      tick_q       <= 1'b0;
      ovf_q        <= 1'b0;
      lap_active_q <= 1'b0;
      lap_prev_q   <= 1'b0;
      lap_val_q    <= '0;
    end else begin
      div_q        <= div_d;
      tick_q       <= tick_d;
      ovf_q        <= ovf_d;
      lap_active_q <= lap_active_d;
      lap_prev_q   <= lap_prev_d;
      lap_val_q    <= lap_val_d;
    end
  end

  assign digits     = lap_active_q ? lap_val_q : live_s;
  assign tick       = tick_q;
  assign lap_active = lap_active_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/bcd_stopwatch_datapath.md
Name: bcd_stopwatch_datapath

Overview:
- Parametrised stopwatch datapath: a prescaler divides clk down to a periodic tick, and the tick advances a chain of NUM_DIGITS cascaded BCD digits.
- Adds pause/resume, synchronous clear, lap-freeze display, and wrap-or-saturate overflow handling.
- Sits between the stopwatch control FSM (run/clear/lap) and the seven-segment decoders (digits bus).

Parameters:
- DIV_WIDTH, 24, width of the prescaler counter.
- TICK_COUNT, 5000000, clk cycles per tick (0.1 s at 50 MHz). Legal range: 2 <= TICK_COUNT < 2^DIV_WIDTH.
- NUM_DIGITS, 3, number of BCD digits. Digit 0 is least significant (tenths). Legal range: >= 1.
- SAT, 0, overflow mode. 0 = wrap to all-zero; 1 = hold at all-nines.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- run  in  1  level; 1 = prescaler counts, 0 = pause (prescaler and digits hold).
- clear  in  1  level; synchronous clear of the time state.
- lap  in  1  lap request; acted on at its rising edge only.
- tick  out  1  registered one-cycle pulse, high in the cycle the digits have just advanced.
- digits  out  4*NUM_DIGITS  displayed BCD value; digit i occupies bits [4i+3:4i].
- lap_active  out  1  1 = digits shows the frozen lap value.
- overflow  out  1  sticky flag; set when the count passes all-nines.

Behaviour:
- Reset (reset==0 at a clock edge):
  - prescaler, live digits, lap register, tick, overflow and lap_active all go to 0.
  - The lap edge-detect register also goes to 0, so lap==1 in the first cycle after reset counts as a rising edge.
- Priority at each edge: reset > clear > normal operation.
- clear==1:
  - prescaler=0, live digits=0, overflow=0, lap_active=0, tick=0.
  - Any lap edge in the same cycle is ignored (the edge-detect register still updates).
- Prescaler:
  - While run==1, increments every cycle.
  - When it equals TICK_COUNT-1, the next edge loads 0 and that edge is a tick edge.
  - run==0 holds its value, so the partial period is preserved across a pause.
- Tick edge:
  - tick register <= 1 (0 on every other edge).
  - Digit 0 increments.
  - Digit i increments iff digits 0..i-1 are all 9 before the edge.
  - Each digit goes 9 -> 0 when it increments; a digit never holds a value above 9.
- All-nines on a tick edge:
  - SAT=0: all digits -> 0 and overflow <= 1.
  - SAT=1: digits stay at all-nines and overflow <= 1.
  - overflow clears only on clear or reset.
- Lap:
  - Rising edge = lap==1 and previous-cycle lap==0.
  - Rising edge with lap_active==0: lap register captures the live digits as they were before this edge (pre-increment if this is also a tick edge); lap_active <= 1.
  - Rising edge with lap_active==1: lap_active <= 0.
  - Live counting continues in both states.
  - Holding lap high for many cycles counts as one event.
- Output select: digits = lap_active ? lap register : live digits. Both sources are registered, so there is no combinational path from inputs to outputs.
- Latency:
  - run asserted with prescaler=0: first tick appears TICK_COUNT edges later.
  - lap edge to digits frozen: 1 edge.

Decomposition:
- Shared package:
  - BCD_W=4 and BCD_MAX=4'd9 constants.
  - localparam helper for TICK_COUNT-1 sized to DIV_WIDTH.
- One sub-module, bcd_digit_cell:
  - Ports: clk, reset, clr, inc_en, hold_max.
  - Holds a 4-bit digit and outputs is_nine.
  - Instantiated NUM_DIGITS times in a generate loop.
  - inc_en for digit i = tick edge AND all lower is_nine.
- Prescaler, lap register, edge detect and output mux stay in the top level.

Test Plan (TICK_COUNT=4, NUM_DIGITS=2 unless stated):
- Count: reset low 2 cycles, then run=1 for 40 cycles -> tick pulses every 4th cycle, exactly 1 cycle wide; digits=8'h10 after the 10th tick; overflow=0.
- Pause: drop run when prescaler=2, hold 10 cycles, raise run -> digits unchanged during the pause; next tick on the 2nd edge after run returns.
- Overflow, SAT=0: count to 8'h99, one more tick -> digits=8'h00, overflow=1, stays 1 over 20 more ticks. Same stimulus with SAT=1 -> digits stay 8'h99, overflow=1.
- Lap:
  - Raise lap for 5 cycles while live=8'h23 -> digits=8'h23 and lap_active=1 while live keeps advancing.
  - Second lap rising edge at live=8'h31 -> digits=8'h31, lap_active=0.
  - Lap edge coincident with a tick at live=8'h29 -> captured value is 8'h29.
- Clear collision: clear=1 in the same cycle as a tick and a lap edge while lap_active=1 and overflow=1 -> next cycle digits=0, tick=0, lap_active=0, overflow=0.
- Reset mid-run: reset=0 for one cycle at digits=8'h57 with lap_active=1 -> all outputs 0 after that edge; with run=1 afterwards, counting restarts with the first tick TICK_COUNT edges later.
